// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the execute-stage ALU.
// Captures decoded fields from ID, forwards operands from EX/MEM and
// MEM/WB, and inserts one-cycle bubbles on load-use hazards and flushes.
module id_ex_stage #(
  parameter int WIDTH = 32,
  parameter int RA    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  // decoded instruction in ID
  input  logic             id_valid,
  input  logic [RA-1:0]    id_rs1,
  input  logic [RA-1:0]    id_rs2,
  input  logic [RA-1:0]    id_rd,
  input  logic [WIDTH-1:0] id_rs1_data,
  input  logic [WIDTH-1:0] id_rs2_data,
  input  logic [WIDTH-1:0] id_imm,
  input  logic             id_alusrc,
  input  logic [3:0]       id_aluctl,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             id_memwrite,
  input  logic             flush,
  // EX/MEM writeback info
  input  logic [RA-1:0]    mem_rd,
  input  logic             mem_regwrite,
  input  logic [WIDTH-1:0] mem_result,
  // MEM/WB writeback info
  input  logic [RA-1:0]    wb_rd,
  input  logic             wb_regwrite,
  input  logic [WIDTH-1:0] wb_result,
  // hazard handshake towards IF/ID
  output logic             stall_id,
  // execute-stage view
  output logic             ex_valid,
  output logic             ex_regwrite,
  output logic             ex_memread,
  output logic             ex_memwrite,
  output logic [RA-1:0]    ex_rd,
  output logic [3:0]       ex_aluctl,
  output logic [WIDTH-1:0] ex_a,
  output logic [WIDTH-1:0] ex_b,
  output logic [WIDTH-1:0] ex_store_data,
  output logic [15:0]      bubble_cnt
);

  // ALU "add" code: the harmless control value carried by bubbles and reset.
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;

  // Saturating increment for the bubble counter.
  function automatic logic [15:0] sat_inc(input logic [15:0] cnt);
    sat_inc = (cnt == 16'hFFFF) ? cnt : cnt + 16'd1;
  endfunction

  // Operand forwarding for one source register. EX/MEM is the younger
  // producer and therefore wins over MEM/WB; x0 is never forwarded.
  function automatic logic [WIDTH-1:0] fwd_sel(
    input logic [RA-1:0]    src,
    input logic [WIDTH-1:0] reg_data,
    input logic [RA-1:0]    m_rd,
    input logic             m_we,
    input logic [WIDTH-1:0] m_res,
    input logic [RA-1:0]    w_rd,
    input logic             w_we,
    input logic [WIDTH-1:0] w_res
  );
    if (m_we && (m_rd != '0) && (m_rd == src)) begin
      fwd_sel = m_res;
    end else if (w_we && (w_rd != '0) && (w_rd == src)) begin
      fwd_sel = w_res;
    end else begin
      fwd_sel = reg_data;
    end
  endfunction

  // Registered pipeline state
  logic             valid_q,    valid_d;
  logic [RA-1:0]    rs1_q,      rs1_d;
  logic [RA-1:0]    rs2_q,      rs2_d;
  logic [RA-1:0]    rd_q,       rd_d;
  logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
  logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
  logic [WIDTH-1:0] imm_q,      imm_d;
  logic             alusrc_q,   alusrc_d;
  logic [3:0]       aluctl_q,   aluctl_d;
  logic             regwrite_q, regwrite_d;
  logic             memread_q,  memread_d;
  logic             memwrite_q, memwrite_d;
  logic [15:0]      bubble_cnt_q, bubble_cnt_d;

  logic             hz;
  logic [WIDTH-1:0] fwd_rs1;
  logic [WIDTH-1:0] fwd_rs2;

  // Load-use hazard: a live load in EX whose destination is read by ID.
  assign hz = valid_q && memread_q && (rd_q != '0) && id_valid &&
              ((id_rs1 == rd_q) || (id_rs2 == rd_q));

  // A flush kills the ID instruction, so it cannot be stalled on.
  assign stall_id = hz && !flush;

  // Next-state selection: capture ID, or load a bubble on flush/hazard.
  always_comb begin
    valid_d      = id_valid;
    rs1_d        = id_rs1;
    rs2_d        = id_rs2;
    rd_d         = id_rd;
    rs1_data_d   = id_rs1_data;
    rs2_data_d   = id_rs2_data;
    imm_d        = id_imm;
    alusrc_d     = id_alusrc;
    aluctl_d     = id_aluctl;
    regwrite_d   = id_regwrite;
    memread_d    = id_memread;
    memwrite_d   = id_memwrite;
    bubble_cnt_d = bubble_cnt_q;

    if (flush || hz) begin
      valid_d    = 1'b0;
      rs1_d      = '0;
      rs2_d      = '0;
      rd_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
      aluctl_d   = ALUCTL_ADD;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
      memwrite_d = 1'b0;
    end

    // Only hazard-induced bubbles are counted; a flush takes precedence.
    if (hz && !flush) begin
      bubble_cnt_d = sat_inc(bubble_cnt_q);
    end
  end

  // Pipeline register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      alusrc_q     <= 1'b0;
      aluctl_q     <= ALUCTL_ADD;
      regwrite_q   <= 1'b0;
      memread_q    <= 1'b0;
      memwrite_q   <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      rs1_data_q   <= rs1_data_d;
      rs2_data_q   <= rs2_data_d;
      imm_q        <= imm_d;
      alusrc_q     <= alusrc_d;
      aluctl_q     <= aluctl_d;
      regwrite_q   <= regwrite_d;
      memread_q    <= memread_d;
      memwrite_q   <= memwrite_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  // Combinational forwarding; also runs on bubbles, which write nothing.
  always_comb begin
    fwd_rs1 = fwd_sel(rs1_q, rs1_data_q, mem_rd, mem_regwrite, mem_result,
                      wb_rd, wb_regwrite, wb_result);
    fwd_rs2 = fwd_sel(rs2_q, rs2_data_q, mem_rd, mem_regwrite, mem_result,
                      wb_rd, wb_regwrite, wb_result);
  end

  assign ex_valid      = valid_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_rd         = rd_q;
  assign ex_aluctl     = aluctl_q;
  assign ex_a          = fwd_rs1;
  assign ex_b          = alusrc_q ? imm_q : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign bubble_cnt    = bubble_cnt_q;

endmodule
